// File: rtl/load_queue_pkg.sv
// Shared types for the load queue and its store-queue neighbour.
package load_queue_pkg;

  localparam int ADDR_HASH_W = 12;

  typedef logic [ADDR_HASH_W-1:0] addr_hash_t;
  typedef logic [3:0] id_t;

  typedef enum logic [1:0] {
    SUBUNIT_LOCAL = 2'd0,
    SUBUNIT_DCACHE = 2'd1,
    SUBUNIT_BUS = 2'd2
  } mem_subunit_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0] fn3;
    logic [3:0] be;
    id_t id;
    mem_subunit_t subunit_id;
    logic strictly_ordered;
  } lq_entry_t;

  typedef struct packed {
    logic [7:0] lq_depth;
    logic [7:0] sq_depth;
  } cpu_config_t;

  localparam cpu_config_t DEFAULT_CPU_CONFIG = '{lq_depth: 8'd4, sq_depth: 8'd4};

endpackage

// File: rtl/load_queue_addr_hash_gen.sv
// Combinational XOR-fold of a 32-bit address into addr_hash_t; shared with the store queue.
module addr_hash_gen
  import load_queue_pkg::*;
(
  input  logic [31:0] addr,
  output addr_hash_t  addr_hash
);

  genvar gi;
  generate
    for (gi = 0; gi < ADDR_HASH_W; gi++) begin : g_fold
      if (gi < 32 - 2 * ADDR_HASH_W) begin : g_three
        assign addr_hash[gi] = addr[gi] ^ addr[gi + ADDR_HASH_W] ^ addr[gi + 2 * ADDR_HASH_W];
      end else begin : g_two
        assign addr_hash[gi] = addr[gi] ^ addr[gi + ADDR_HASH_W];
      end
    end
  endgenerate

endmodule

// File: rtl/load_queue.sv
// In-order load queue holding each load until its older conflicting stores have issued.
// Optional same-cycle bypass into an empty queue: LOAD_QUEUE_BYPASS_EN.
module load_queue
  import load_queue_pkg::*;
#(
  parameter int LQ_DEPTH = 4,
  parameter int SQ_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lq_push,
  input  lq_entry_t           lq_in,
  output addr_hash_t          addr_hash,
  input  logic [SQ_DEPTH-1:0] potential_store_conflicts,
  output logic                lq_full,
  output logic                lq_empty,
  output logic                lq_valid,
  output lq_entry_t           lq_out,
  input  logic                lq_pop,
  output logic [SQ_DEPTH-1:0] prev_store_conflicts,
  input  logic                store_conflict
);

  localparam int IDX_W = $clog2(LQ_DEPTH);

  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             lq_full_q, lq_full_d;

  lq_entry_t           entry_mem [LQ_DEPTH];
  logic [SQ_DEPTH-1:0] conf_mem  [LQ_DEPTH];

  logic bypass;
  logic push_en;
  logic pop_en;

  addr_hash_gen u_addr_hash_gen (
    .addr      (lq_in.addr),
    .addr_hash (addr_hash)
  );

  assign lq_empty = (count_q == '0);
  assign lq_full  = lq_full_q;

`ifdef LOAD_QUEUE_BYPASS_EN
  assign bypass = lq_empty & lq_push & (potential_store_conflicts == '0);
`else
  assign bypass = 1'b0;
`endif

  // A bypassed load that is accepted the same cycle never touches storage.
  assign push_en = lq_push & ~(bypass & lq_pop);
  assign pop_en  = lq_pop & ~bypass;

  always_comb begin
    wr_idx_d  = push_en ? wr_idx_q + IDX_W'(1) : wr_idx_q;
    rd_idx_d  = pop_en ? rd_idx_q + IDX_W'(1) : rd_idx_q;
    count_d   = count_q + (IDX_W + 1)'(push_en) - (IDX_W + 1)'(pop_en);
    lq_full_d = (count_d == (IDX_W + 1)'(LQ_DEPTH));
  end

  always_comb begin
    lq_out               = entry_mem[rd_idx_q];
    prev_store_conflicts = lq_empty ? '0 : conf_mem[rd_idx_q];
    lq_valid             = ~lq_empty & ~store_conflict;
    if (bypass) begin
      lq_out               = lq_in;
      prev_store_conflicts = '0;
      lq_valid             = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      count_q   <= '0;
      lq_full_q <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      count_q   <= count_d;
      lq_full_q <= lq_full_d;
    end
  end

  // Storage is deliberately unreset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push_en) begin
      entry_mem[wr_idx_q] <= lq_in;
      conf_mem[wr_idx_q]  <= potential_store_conflicts;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(lq_push && lq_full_q)) else $error("lq overflow");
      assert (!(lq_pop && !lq_valid)) else $error("lq underflow");
    end
  end

endmodule
